// File: rtl/im_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package im_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int IM_DEPTH        = 256;
  localparam int BYTES_PER_WORD  = 4;
  localparam int WORD_ADDR_SHIFT = 2;

  // A load length is usable only if it names at least one word and fits the memory.
  function automatic logic len_legal(input int len, input int depth);
    return (len >= 1) && (len <= depth);
  endfunction

endpackage

// File: rtl/im_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master = the loader itself, slave = the byte source / memory side.
interface im_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        w_en;
  logic [31:0] w_addr;
  logic [31:0] w_data;

  modport master (
    input  byte_valid, byte_data,
    output byte_ready, w_en, w_addr, w_data
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, w_en, w_addr, w_data
  );
endinterface

// File: rtl/word_packer.sv
// Collects bytes little-endian into a 32-bit word: first byte lands in [7:0].
// `word` already includes a byte being accepted this cycle, and `full` flags
// the accept that completes the word so the caller can capture it directly.
module word_packer
  import im_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        full
);

  localparam int                LANE_W    = $clog2(BYTES_PER_WORD);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [31:0]       word_q, word_d;

  // Insert the incoming byte into its lane and advance the lane; clear wins.
  always_comb begin
    word = word_q;
    if (accept) begin
      word[{lane_q, 3'b000} +: 8] = byte_in;
    end
    full   = accept && (lane_q == LAST_LANE);
    lane_d = lane_q;
    word_d = word;
    if (clear) begin
      lane_d = '0;
      word_d = '0;
    end else if (accept) begin
      lane_d = lane_q + LANE_W'(1);
    end
  end

  // Lane counter and partial word registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
      word_q <= '0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/im_loader.sv
// Program loader: packs a byte stream into words and writes them to the
// instruction memory at 0, 4, 8, ... while holding the CPU in reset.
module im_loader
  import im_loader_pkg::*;
#(
  parameter int DEPTH = IM_DEPTH,
  parameter int LEN_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len_words,
  input  logic             abort,
  im_loader_if.master      bus,
  output logic             busy,
  output logic             cpu_hold,
  output logic             done,
  output logic             err
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] cnt_inc;
  logic [31:0]      w_addr_q, w_addr_d;
  logic [31:0]      w_data_q, w_data_d;
  logic             w_en_q, w_en_d;
  logic             byte_ready_q, byte_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             pk_clear;
  logic             pk_accept;
  logic             pk_full;
  logic [31:0]      pk_word;

  // byte_ready is only ever set in RECV, so it alone qualifies a handshake.
  assign pk_accept = bus.byte_valid & byte_ready_q;
  assign cnt_inc   = cnt_q + LEN_W'(1);

  word_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clear   (pk_clear),
    .accept  (pk_accept),
    .byte_in (bus.byte_data),
    .word    (pk_word),
    .full    (pk_full)
  );

  // Next-state and next-output logic of the load sequencer.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    w_addr_d     = w_addr_q;
    w_data_d     = w_data_q;
    w_en_d       = 1'b0;
    byte_ready_d = byte_ready_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    pk_clear     = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          done_d = 1'b0;
          if (!len_legal(int'(len_words), DEPTH)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            err_d        = 1'b0;
            len_d        = len_words;
            cnt_d        = '0;
            w_addr_d     = '0;
            busy_d       = 1'b1;
            byte_ready_d = 1'b1;
            pk_clear     = 1'b1;
            state_d      = RECV;
          end
        end
      end

      RECV: begin
        if (abort) begin
          err_d        = 1'b1;
          busy_d       = 1'b0;
          byte_ready_d = 1'b0;
          pk_clear     = 1'b1;
          state_d      = IDLE;
        end else if (pk_full) begin
          w_data_d     = pk_word;
          w_en_d       = 1'b1;
          byte_ready_d = 1'b0;
          state_d      = WRITE;
        end
      end

      WRITE: begin
        if (abort) begin
          err_d    = 1'b1;
          busy_d   = 1'b0;
          pk_clear = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_inc;
          // The address stays on the last word so it never passes the top.
          if (cnt_inc == len_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            w_addr_d     = w_addr_q + (32'd1 << WORD_ADDR_SHIFT);
            byte_ready_d = 1'b1;
            pk_clear     = 1'b1;
            state_d      = RECV;
          end
        end
      end

      default: begin
        state_d      = IDLE;
        busy_d       = 1'b0;
        byte_ready_d = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
      w_en_q       <= 1'b0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
      w_en_q       <= w_en_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // An abort landing on the write cycle must kill the strobe before the
  // memory samples it, hence the combinational gate on w_en.
  assign bus.byte_ready = byte_ready_q;
  assign bus.w_en       = w_en_q & ~abort;
  assign bus.w_addr     = w_addr_q;
  assign bus.w_data     = w_data_q;
  assign busy           = busy_q;
  assign cpu_hold       = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: doc/im_loader.md
# im_loader

Program loader that writes the instruction memory: accepts a byte stream over a valid/ready handshake and packs it into little-endian 32-bit words. It writes each word to consecutive word-aligned byte addresses starting at 0 and holds the CPU while loading. It sits between the host/debug byte source and the write port of the instruction memory, which is read by the datapath as `memory[r_addr>>2]`.

## Interface
Parameters:
- DEPTH, 256, number of 32-bit words in instruction memory; legal load length 1..DEPTH
- LEN_W, 9, width of `len_words` (must hold DEPTH)

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a load; sampled only in IDLE or DONE
- len_words  in  LEN_W  number of words to load; latched when `start` is accepted
- abort  in  1  cancels a load in progress
- byte_valid  in  1  source has a byte on `byte_data`
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- w_en  out  1  instruction-memory write strobe, one cycle per word
- w_addr  out  32  byte address of the word; always a multiple of 4
- w_data  out  32  packed word
- busy  out  1  load in progress (RECV or WRITE)
- cpu_hold  out  1  equals `busy`; keeps the CPU PC in reset while loading
- done  out  1  last load completed without error; held until the next accepted `start`
- err  out  1  last start/load was rejected or aborted; held until the next accepted `start`

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE/DONE + `start`:
  - If `len_words` is 0 or greater than DEPTH: set `err`=1, clear `done`, go to IDLE.
  - Otherwise: latch the length, set word counter=0, byte lane=0, `w_addr`=0, clear `done`/`err`, go to RECV.
- RECV:
  - `byte_ready`=1.
  - On `byte_valid && byte_ready`, the byte goes to lane `k` (bits 8k+7:8k); the first byte goes to [7:0].
  - After lane 3 is accepted, go to WRITE.
- WRITE:
  - `w_en`=1 for exactly this cycle, with `w_data` equal to the assembled word.
  - `byte_ready`=0.
  - Next cycle: `w_addr`+=4 and counter+=1.
  - If the counter now equals the length, go to DONE with `done`=1; otherwise go to RECV with lane=0.
- `abort` in RECV or WRITE: go to IDLE and set `err`=1. The partial word is discarded. An abort in the WRITE cycle suppresses `w_en` for that cycle. `abort` has priority over everything else.
- `start` while `busy` is ignored.
- `w_addr` never exceeds 4*(DEPTH-1); there is no wrap-around.

## Timing
- Reset values: state IDLE; `byte_ready`, `w_en`, `busy`, `cpu_hold`, `done`, `err` = 0; `w_addr`, `w_data`, counters = 0.
- Accepted `start` at edge N: `busy`=1 and `byte_ready`=1 from cycle N+1.
- 4th byte accepted at edge M: `w_en`=1 during cycle M+1. If the word was not the last, `byte_ready`=1 again from cycle M+2.
- Throughput: at most one word per 5 cycles with continuous `byte_valid`.
- Last write at cycle W: `done`=1 and `busy`=0 from cycle W+1.
- `w_addr`/`w_data` are stable for the whole `w_en` cycle; the memory captures them on the edge that ends that cycle.
- `rst` mid-load: immediate return to reset values. Memory contents already written are unchanged.

## Structure
- Package `im_loader_pkg`: state enum (IDLE, RECV, WRITE, DONE), `IM_DEPTH`=256, `BYTES_PER_WORD`=4, `WORD_ADDR_SHIFT`=2.
- Sub-module `word_packer`: lane counter plus shift/insert of bytes into a 32-bit word, with `clear` and `full` signals. The FSM, address counter and word counter stay in `im_loader`.

## Test plan
- **Single word:** `start` with `len_words`=1, bytes 0x13,0x00,0x00,0x00 back-to-back -> one `w_en` pulse with `w_addr`=0x0 and `w_data`=0x00000013; `done`=1; `busy`=0.
- **Three words with gaps:** `len_words`=3, random `byte_valid` gaps -> `w_addr` 0x0, 0x4, 0x8 in order with correctly packed data; no `w_en` outside WRITE; exactly 3 pulses.
- **Full depth:** `len_words`=256 -> last write at `w_addr`=0x3FC; a readback model of `memory[addr>>2]` matches all 256 words.
- **Illegal length:** `start` with `len_words`=0, and again with 257 -> `err`=1, `busy` never asserted, no `w_en`.
- **Abort:** `abort` after 6 bytes of a 2-word load -> exactly 1 write (addr 0x0), `err`=1, state IDLE. A following `start` with length 1 clears `err` and loads correctly.
- **Reset mid-load:** `rst` asserted during WRITE of word 2 -> outputs at reset values asynchronously, `w_en`=0 in the same cycle; `start`, `byte_valid` and `abort` during reset are ignored.
